// File: rtl/mod_exp_ctrl_if.sv
// Stream bundle around the exponentiation controller: job input, the three
// modulo-unit channels (dividend, divisor, remainder) and the result output.
interface mod_exp_ctrl_if #(parameter int SIZE = 128);
   logic [SIZE/2-1:0] input_base_tdata;
   logic [SIZE/2-1:0] input_exp_tdata;
   logic [SIZE/2-1:0] input_mod_tdata;
   logic              input_tvalid;
   logic              input_tready;
   logic [SIZE-1:0]   mod_dividen_tdata;
   logic              mod_dividen_tvalid;
   logic              mod_dividen_tready;
   logic [SIZE/2-1:0] mod_divisor_tdata;
   logic              mod_divisor_tvalid;
   logic              mod_divisor_tready;
   logic [SIZE/2-1:0] mod_result_tdata;
   logic              mod_result_tvalid;
   logic              mod_result_tready;
   logic [SIZE/2-1:0] result_tdata;
   logic              result_err;
   logic              result_tvalid;
   logic              result_tready;

   // Controller side: initiator of the modulo streams, consumer of the job.
   modport master (
      input  input_base_tdata, input_exp_tdata, input_mod_tdata, input_tvalid,
      output input_tready,
      output mod_dividen_tdata, mod_dividen_tvalid,
      input  mod_dividen_tready,
      output mod_divisor_tdata, mod_divisor_tvalid,
      input  mod_divisor_tready,
      input  mod_result_tdata, mod_result_tvalid,
      output mod_result_tready,
      output result_tdata, result_err, result_tvalid,
      input  result_tready
   );

   modport slave (
      output input_base_tdata, input_exp_tdata, input_mod_tdata, input_tvalid,
      input  input_tready,
      input  mod_dividen_tdata, mod_dividen_tvalid,
      output mod_dividen_tready,
      input  mod_divisor_tdata, mod_divisor_tvalid,
      output mod_divisor_tready,
      output mod_result_tdata, mod_result_tvalid,
      input  mod_result_tready,
      input  result_tdata, result_err, result_tvalid,
      output result_tready
   );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply controller computing base^exp mod m; products
// are formed locally and every reduction goes through the external modulo unit.
module mod_exp_ctrl #(
   parameter int SIZE = 128
) (
   input  logic           clk,
   input  logic           rst,
   mod_exp_ctrl_if.master bus
);
   localparam int HALF = SIZE / 2;

   typedef enum logic [3:0] {
      IDLE, RED_SEND, RED_WAIT, MUL_SEND, MUL_WAIT,
      SQR_SEND, SQR_WAIT, CHECK, SQR_CHK, FIN, DONE
   } state_t;

   state_t state, state_next;

   logic [HALF-1:0] r, b, e, m;
   logic [SIZE-1:0] p;
   logic            dividen_sent, divisor_sent;
   logic [HALF-1:0] result_data;
   logic            result_flag;

   logic            in_send;
   logic            job_accept, result_accept;
   logic            dividen_hs, divisor_hs, rem_hs;
   logic [SIZE-1:0] r_ext, b_ext;

   assign in_send       = (state == RED_SEND) || (state == MUL_SEND) || (state == SQR_SEND);
   assign job_accept    = bus.input_tvalid && bus.input_tready;
   assign result_accept = bus.result_tvalid && bus.result_tready;
   assign dividen_hs    = bus.mod_dividen_tvalid && bus.mod_dividen_tready;
   assign divisor_hs    = bus.mod_divisor_tvalid && bus.mod_divisor_tready;
   assign rem_hs        = bus.mod_result_tvalid && bus.mod_result_tready;
   assign r_ext         = {{HALF{1'b0}}, r};
   assign b_ext         = {{HALF{1'b0}}, b};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (job_accept) state_next = (bus.input_mod_tdata == '0) ? DONE : RED_SEND;
         RED_SEND: if (dividen_sent && divisor_sent) state_next = RED_WAIT;
         MUL_SEND: if (dividen_sent && divisor_sent) state_next = MUL_WAIT;
         SQR_SEND: if (dividen_sent && divisor_sent) state_next = SQR_WAIT;
         RED_WAIT: if (rem_hs) state_next = CHECK;
         MUL_WAIT: if (rem_hs) state_next = SQR_CHK;
         SQR_WAIT: if (rem_hs) state_next = CHECK;
         CHECK: begin
            if (e == '0)  state_next = FIN;
            else if (e[0]) state_next = MUL_SEND;
            else           state_next = SQR_CHK;
         end
         // The top exponent bit needs no square after it, so skip straight to FIN.
         SQR_CHK:  state_next = (e[HALF-1:1] == '0) ? FIN : SQR_SEND;
         FIN:      state_next = DONE;
         DONE:     if (result_accept) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.input_tready       = 1'b0;
      bus.mod_dividen_tvalid = 1'b0;
      bus.mod_divisor_tvalid = 1'b0;
      bus.mod_result_tready  = 1'b0;
      bus.result_tvalid      = 1'b0;
      case (state)
         IDLE: bus.input_tready = 1'b1;
         RED_SEND, MUL_SEND, SQR_SEND: begin
            bus.mod_dividen_tvalid = !dividen_sent;
            bus.mod_divisor_tvalid = !divisor_sent;
         end
         RED_WAIT, MUL_WAIT, SQR_WAIT: bus.mod_result_tready = 1'b1;
         DONE: bus.result_tvalid = 1'b1;
         default: ;
      endcase
   end

   assign bus.mod_dividen_tdata = p;
   assign bus.mod_divisor_tdata = m;
   assign bus.result_tdata      = result_data;
   assign bus.result_err        = result_flag;

   // Sent flags only live inside a SEND state; P is loaded on the way into each SEND.
   always_ff @(posedge clk) begin
      if (rst) begin
         r            <= '0;
         b            <= '0;
         e            <= '0;
         m            <= '0;
         p            <= '0;
         dividen_sent <= 1'b0;
         divisor_sent <= 1'b0;
         result_data  <= '0;
         result_flag  <= 1'b0;
      end else begin
         if (in_send) begin
            if (dividen_hs) dividen_sent <= 1'b1;
            if (divisor_hs) divisor_sent <= 1'b1;
         end else begin
            dividen_sent <= 1'b0;
            divisor_sent <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (job_accept) begin
                  b           <= bus.input_base_tdata;
                  e           <= bus.input_exp_tdata;
                  m           <= bus.input_mod_tdata;
                  r           <= HALF'(1);
                  p           <= {{HALF{1'b0}}, bus.input_base_tdata};
                  result_data <= '0;
                  result_flag <= (bus.input_mod_tdata == '0);
               end
            end
            RED_WAIT: if (rem_hs) b <= bus.mod_result_tdata;
            MUL_WAIT: if (rem_hs) r <= bus.mod_result_tdata;
            SQR_WAIT: begin
               if (rem_hs) begin
                  b <= bus.mod_result_tdata;
                  e <= e >> 1;
               end
            end
            CHECK: if (e != '0 && e[0]) p <= r_ext * b_ext;
            SQR_CHK: begin
               if (e[HALF-1:1] != '0) p <= b_ext * b_ext;
               else                   e <= '0;
            end
            // R is already reduced except when m==1 and no multiply ever ran.
            FIN: begin
               result_data <= (m == HALF'(1)) ? '0 : r;
               result_flag <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Modular exponentiation controller for the ElGamal datapath: computes base^exp mod m by right-to-left square-and-multiply.
- Acts as the initiator/consumer end of the modulo unit's stream protocol. It drives the dividend and divisor streams, and consumes the remainder stream.
- The 64x64 multiplication is done internally; every reduction is delegated to the external modulo unit.

Parameters:
- SIZE, 128, dividend/product width; operand, modulus and result width is SIZE/2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- input_base_tdata  in  SIZE/2  base
- input_exp_tdata  in  SIZE/2  exponent
- input_mod_tdata  in  SIZE/2  modulus m
- input_tvalid  in  1  job valid; the three fields above are one beat
- input_tready  out  1  high only in IDLE
- mod_dividen_tdata  out  SIZE  dividend to modulo unit
- mod_dividen_tvalid  out  1  dividend valid
- mod_dividen_tready  in  1  dividend accepted
- mod_divisor_tdata  out  SIZE/2  divisor to modulo unit, always the latched m
- mod_divisor_tvalid  out  1  divisor valid
- mod_divisor_tready  in  1  divisor accepted
- mod_result_tdata  in  SIZE/2  remainder from modulo unit
- mod_result_tvalid  in  1  remainder valid
- mod_result_tready  out  1  high only in *_WAIT states
- result_tdata  out  SIZE/2  base^exp mod m
- result_err  out  1  set with result when m==0
- result_tvalid  out  1  result valid
- result_tready  in  1  downstream accepts

Behaviour:
- Reset (sync, any state, including mid-job):
  - State goes to IDLE.
  - All outputs go to 0 except input_tready=1.
  - Internal registers R, B, E, M are cleared.
  - The in-flight modulo transaction is abandoned. Its remainder is not accepted because mod_result_tready=0.
- IDLE:
  - On input_tvalid & input_tready: latch B=base, E=exp, M=mod, R=1.
  - If M==0: go to DONE with result 0 and result_err=1. No modulo traffic occurs.
  - Otherwise go to RED_SEND.
- Each *_SEND state (RED_SEND, MUL_SEND, SQR_SEND):
  - Product register P is loaded on state entry:
    - RED_SEND: P = zero-extended B.
    - MUL_SEND: P = R*B, full SIZE bits.
    - SQR_SEND: P = B*B.
  - On entry, assert both mod_dividen_tvalid and mod_divisor_tvalid. tdata is held stable while valid.
  - Each valid drops independently on its own ready handshake. Sent flags track the two channels; simultaneous or any-order readies are legal.
  - Advance to the matching *_WAIT in the cycle after both channels have completed.
- Each *_WAIT state:
  - mod_result_tready=1.
  - On a result handshake:
    - RED_WAIT: B=rem, then go to CHECK.
    - MUL_WAIT: R=rem, then go to SQR_CHK.
    - SQR_WAIT: B=rem, E=E>>1, then go to CHECK.
- CHECK:
  - If E==0: go to FIN.
  - Else if E[0]: go to MUL_SEND.
  - Else: go to SQR_CHK.
- SQR_CHK:
  - If (E>>1)==0: E=0, go to FIN. The final square is skipped.
  - Else: go to SQR_SEND.
- FIN:
  - result_tdata = (M==1) ? 0 : R, so exp 0 with m 1 yields 0.
  - result_err=0.
  - Go to DONE.
- DONE:
  - result_tvalid=1 and data held until result_tready.
  - On the handshake, drop valid and go to IDLE.
  - Latency of the result_tready-to-input_tready path is 1 cycle.
- Widths:
  - Products are exact, 2*(SIZE/2) = SIZE bits, so there is no overflow.
  - B and R are always < M after the first reduction.
- Transaction count for exp≠0: 1 + popcount(E) + (bitlength(E) − 1) modulo operations.

Test Plan:
- The bench uses a behavioural modulo responder with random ready/valid delays of 0–5 cycles.
- base=4, exp=13, m=497 -> result 445, err=0, exactly 7 modulo transactions.
- base=2, exp=10, m=1000 -> 24. Then base=1000, exp=1, m=7 -> 6, which exercises base ≥ m reduction.
- Boundaries:
  - exp=0, m=497 -> 1.
  - base=5, exp=0, m=1 -> 0.
  - m=0 -> result 0, err=1, zero modulo transactions.
- Handshake skew: mod_divisor_tready 3 cycles before mod_dividen_tready, then the reverse order -> each valid drops on its own handshake and tdata stays stable. Hold result_tready=0 for 10 cycles -> result_tvalid and data held, input_tready stays 0.
- Reset mid-job: assert rst during MUL_WAIT with a pending remainder -> next cycle all outputs are at reset values and input_tready=1. A new job with base=3, exp=5, m=7 -> 5.
- Back-to-back: 20 random 64-bit jobs against a reference model -> all results match and no job is dropped or duplicated.
